// File: rtl/clock_step_controller.sv
// Run/step/halt controller that drives the enable of a clock-gating cell and
// counts the cycles the gated clock was allowed to run.
module clock_step_controller #(
  parameter int COUNT_WIDTH = 16,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   bp_hit,
  output logic                   enable_clk,
  output logic                   halted,
  output logic                   bp_halted,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] step_remaining,
  output logic [CYCLE_WIDTH-1:0] cycles_run
);

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] remaining_next;
  logic                   done_next;
  logic                   bp_next;
  logic                   clear_count;
  logic                   accept;

  assign cmd_ready = (state != STEP);
  assign halted    = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next     = state;
    remaining_next = step_remaining;
    done_next      = 1'b0;
    bp_next        = bp_halted;
    clear_count    = accept && (cmd_op == OP_CLEAR);

    if (accept && (cmd_op != OP_CLEAR)) begin
      bp_next = 1'b0;
    end

    // STEP is never accepted while stepping, so it only arrives from IDLE or RUN
    if (accept && (cmd_op == OP_STEP)) begin
      if (cmd_count == '0) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next     = STEP;
        remaining_next = cmd_count;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept && (cmd_op == OP_HALT)) begin
            done_next = 1'b1;
          end else if (accept && (cmd_op == OP_RUN)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (accept && (cmd_op == OP_HALT)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (accept && (cmd_op == OP_RUN)) begin
            state_next = RUN;
          end else if (bp_hit) begin
            state_next = IDLE;
            bp_next    = 1'b1;
            done_next  = 1'b1;
          end
        end
        STEP: begin
          if (step_remaining <= COUNT_WIDTH'(1)) begin
            state_next     = IDLE;
            remaining_next = '0;
            done_next      = 1'b1;
          end else begin
            remaining_next = step_remaining - COUNT_WIDTH'(1);
          end
        end
        default: begin
          state_next     = IDLE;
          remaining_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      enable_clk     <= 1'b0;
      done           <= 1'b0;
      bp_halted      <= 1'b0;
      step_remaining <= '0;
      cycles_run     <= '0;
    end else begin
      state          <= state_next;
      enable_clk     <= (state_next != IDLE);
      done           <= done_next;
      bp_halted      <= bp_next;
      step_remaining <= remaining_next;
      // a clear wins over the increment of the same edge
      if (clear_count) begin
        cycles_run <= '0;
      end else if (enable_clk) begin
        cycles_run <= cycles_run + CYCLE_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench for clock_step_controller: a behavioural model predicts every
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_clock_step_controller;

  localparam int COUNT_WIDTH = 16;
  localparam int CYCLE_WIDTH = 4;
  localparam int CYC_MOD     = 1 << CYCLE_WIDTH;

  localparam logic [1:0] HALT  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] STEP  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic                   bp_hit;
  logic                   enable_clk;
  logic                   halted;
  logic                   bp_halted;
  logic                   done;
  logic [COUNT_WIDTH-1:0] step_remaining;
  logic [CYCLE_WIDTH-1:0] cycles_run;

  always #5 clock = ~clock;

  clock_step_controller #(
    .COUNT_WIDTH(COUNT_WIDTH),
    .CYCLE_WIDTH(CYCLE_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .bp_hit(bp_hit),
    .enable_clk(enable_clk),
    .halted(halted),
    .bp_halted(bp_halted),
    .done(done),
    .step_remaining(step_remaining),
    .cycles_run(cycles_run)
  );

  typedef struct {
    bit en;
    bit ready;
    bit idle;
    bit bp;
    bit dn;
    int rem;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vectors = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  // model: free-running flag plus the number of stepped cycles still owed
  bit m_running = 0;
  bit m_bp      = 0;
  bit m_done    = 0;
  int m_owed    = 0;
  int m_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelEdge(input bit rst, input bit v, input logic [1:0] op, input int n, input bit bp);
    bit en_now;
    bit acc;
    if (rst) begin
      m_running = 0;
      m_bp      = 0;
      m_done    = 0;
      m_owed    = 0;
      m_count   = 0;
      return;
    end
    en_now = m_running || (m_owed > 0);
    acc    = v && (m_owed == 0);
    m_done = 0;
    if (en_now) m_count = (m_count + 1) % CYC_MOD;
    if (m_owed > 0) begin
      m_owed = m_owed - 1;
      if (m_owed == 0) m_done = 1;
    end else if (acc && op == HALT) begin
      m_running = 0;
      m_done    = 1;
      m_bp      = 0;
    end else if (acc && op == RUN) begin
      m_running = 1;
      m_bp      = 0;
    end else if (acc && op == STEP) begin
      m_running = 0;
      m_owed    = n;
      m_bp      = 0;
      if (n == 0) m_done = 1;
    end else if (m_running && bp) begin
      m_running = 0;
      m_bp      = 1;
      m_done    = 1;
    end
    if (acc && op == CLEAR) m_count = 0;
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [1:0] op, input int n, input bit bp);
    exp_t e;
    reset     = rst;
    cmd_valid = v;
    cmd_op    = op;
    cmd_count = COUNT_WIDTH'(n);
    bp_hit    = bp;
    @(posedge clock);
    modelEdge(rst, v, op, n, bp);
    e.en    = m_running || (m_owed > 0);
    e.ready = (m_owed == 0);
    e.idle  = !e.en;
    e.bp    = m_bp;
    e.dn    = m_done;
    e.rem   = m_owed;
    e.cyc   = m_count;
    exp_q.push_back(e);
    n_vectors++;
    #1;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, HALT, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("enable_clk", 32'(enable_clk), 32'(e.en));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(e.ready));
        checkOutput("halted", 32'(halted), 32'(e.idle));
        checkOutput("bp_halted", 32'(bp_halted), 32'(e.bp));
        checkOutput("done", 32'(done), 32'(e.dn));
        checkOutput("step_remaining", 32'(step_remaining), 32'(e.rem));
        checkOutput("cycles_run", 32'(cycles_run), 32'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    int stalled;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = HALT;
    cmd_count = '0;
    bp_hit    = 1'b0;

    applyStimulus(1, 0, HALT, 0, 0);
    applyStimulus(1, 0, HALT, 0, 0);
    checkOutput("reset_halted", 32'(halted), 32'd1);
    checkOutput("reset_ready", 32'(cmd_ready), 32'd1);

    // STEP 3: three enabled cycles then a done pulse
    applyStimulus(0, 1, STEP, 3, 0);
    checkOutput("step3_rem3", 32'(step_remaining), 32'd3);
    checkOutput("step3_en", 32'(enable_clk), 32'd1);
    idleCycles(1);
    checkOutput("step3_rem2", 32'(step_remaining), 32'd2);
    idleCycles(1);
    checkOutput("step3_rem1", 32'(step_remaining), 32'd1);
    idleCycles(1);
    checkOutput("step3_rem0", 32'(step_remaining), 32'd0);
    checkOutput("step3_done", 32'(done), 32'd1);
    checkOutput("step3_en_off", 32'(enable_clk), 32'd0);
    checkOutput("step3_cycles", 32'(cycles_run), 32'd3);
    idleCycles(1);
    checkOutput("step3_done_once", 32'(done), 32'd0);

    // RUN for 10 cycles, then HALT
    applyStimulus(0, 1, CLEAR, 0, 0);
    applyStimulus(0, 1, RUN, 0, 0);
    idleCycles(10);
    applyStimulus(0, 1, HALT, 0, 0);
    checkOutput("halt_en", 32'(enable_clk), 32'd0);
    checkOutput("halt_done", 32'(done), 32'd1);
    checkOutput("halt_cycles", 32'(cycles_run), 32'd11);
    idleCycles(2);

    // breakpoint while running
    applyStimulus(0, 1, RUN, 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, HALT, 0, 1);
    checkOutput("bp_halted_set", 32'(bp_halted), 32'd1);
    checkOutput("bp_done", 32'(done), 32'd1);
    checkOutput("bp_idle", 32'(halted), 32'd1);
    applyStimulus(0, 1, RUN, 0, 0);
    checkOutput("bp_halted_clr", 32'(bp_halted), 32'd0);
    applyStimulus(0, 1, HALT, 0, 1);
    checkOutput("halt_beats_bp", 32'(bp_halted), 32'd0);
    idleCycles(1);

    // STEP 0, then STEP 5 with a command held against it
    applyStimulus(0, 1, STEP, 0, 0);
    checkOutput("step0_done", 32'(done), 32'd1);
    checkOutput("step0_en", 32'(enable_clk), 32'd0);
    idleCycles(1);
    applyStimulus(0, 1, STEP, 5, 0);
    stalled = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready == 1'b0) stalled++;
      applyStimulus(0, 1, HALT, 0, 0);
    end
    checkOutput("step5_stalled", 32'(stalled), 32'd5);
    checkOutput("step5_ready", 32'(cmd_ready), 32'd1);
    checkOutput("step5_done", 32'(done), 32'd1);
    idleCycles(1);

    // counter wrap at 4 bits, then clear while running
    applyStimulus(0, 1, CLEAR, 0, 0);
    applyStimulus(0, 1, RUN, 0, 0);
    idleCycles(14);
    checkOutput("wrap_14", 32'(cycles_run), 32'd14);
    idleCycles(1);
    checkOutput("wrap_15", 32'(cycles_run), 32'd15);
    idleCycles(1);
    checkOutput("wrap_0", 32'(cycles_run), 32'd0);
    idleCycles(1);
    checkOutput("wrap_1", 32'(cycles_run), 32'd1);
    applyStimulus(0, 1, CLEAR, 0, 0);
    checkOutput("clear_in_run", 32'(cycles_run), 32'd0);
    checkOutput("clear_keeps_en", 32'(enable_clk), 32'd1);
    applyStimulus(0, 1, HALT, 0, 0);

    // reset in the middle of a long STEP, with a command presented alongside
    applyStimulus(0, 1, STEP, 100, 0);
    idleCycles(10);
    applyStimulus(1, 1, RUN, 0, 0);
    checkOutput("rst_en", 32'(enable_clk), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rem", 32'(step_remaining), 32'd0);
    checkOutput("rst_cycles", 32'(cycles_run), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    idleCycles(1);
    checkOutput("rst_no_done", 32'(done), 32'd0);
    checkOutput("rst_cmd_dropped", 32'(enable_clk), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    $urandom_range(0, 4) == 0);
    end

    idleCycles(2);
    @(negedge clock);
    #1;
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_step_controller.md
CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the step count.
REQ-002 SHALL have parameter CYCLE_WIDTH, default 32: width of the enabled-cycle counter.
REQ-003 SHALL have port clock, input, 1: free-running clock, the same clock that feeds the gating cell; one clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: command present.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted this cycle when high together with cmd_valid.
REQ-007 SHALL have port cmd_op, input, 2: 00 HALT, 01 RUN, 10 STEP, 11 CLEAR_COUNT.
REQ-008 SHALL have port cmd_count, input, COUNT_WIDTH: step count; used only by STEP.
REQ-009 SHALL have port bp_hit, input, 1: breakpoint request from the core/debug logic.
REQ-010 SHALL have port enable_clk, output, 1: registered enable to the clock gate.
REQ-011 SHALL have port halted, output, 1: high when in IDLE.
REQ-012 SHALL have port bp_halted, output, 1: last stop was caused by bp_hit.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port step_remaining, output, COUNT_WIDTH: enabled cycles still owed by the current STEP.
REQ-015 SHALL have port cycles_run, output, CYCLE_WIDTH: count of cycles with enable_clk high.

Function
REQ-016 SHALL implement states IDLE, RUN and STEP; enable_clk SHALL be a register equal to 1 exactly in RUN and STEP.
REQ-017 SHALL drive cmd_ready = 1 in IDLE and RUN and 0 in STEP; no command is accepted during STEP.
REQ-018 SHALL treat an accepted command as accepted at edge k; every effect SHALL be visible from cycle k+1.
REQ-019 RUN accepted in IDLE SHALL go to RUN with enable_clk=1 from k+1; RUN in RUN SHALL be a no-op; RUN SHALL produce no done pulse.
REQ-020 HALT accepted in RUN SHALL go to IDLE with enable_clk=0 and done=1 at k+1; HALT in IDLE SHALL leave state unchanged and pulse done at k+1.
REQ-021 STEP with N>0 accepted in IDLE SHALL hold enable_clk=1 for exactly N cycles (k+1..k+N), then IDLE with enable_clk=0 and done=1 at k+N+1.
REQ-022 STEP with N=0 SHALL stay in IDLE and pulse done at k+1.
REQ-023 STEP accepted in RUN SHALL stop free running and then behave as STEP N from k+1 (enable stays high N cycles, no low gap).
REQ-024 step_remaining SHALL load N at k+1 and decrement by 1 each STEP cycle, reaching 0 in the cycle the block returns to IDLE; it SHALL be 0 outside STEP.
REQ-025 bp_hit sampled high in RUN SHALL go to IDLE with enable_clk=0, bp_halted=1 and done=1 next cycle; bp_hit SHALL be ignored in IDLE and STEP.
REQ-026 If bp_hit and an accepted HALT coincide in RUN, HALT wins and bp_halted stays 0.
REQ-027 bp_halted SHALL clear on the cycle after any accepted command other than CLEAR_COUNT.
REQ-028 cycles_run SHALL increment by 1 on each rising edge where enable_clk=1, wrapping from 2^CYCLE_WIDTH-1 to 0.
REQ-029 CLEAR_COUNT SHALL set cycles_run to 0 at k+1, overriding a coincident increment, without changing state, enable_clk or done.
REQ-030 done SHALL never be high for two consecutive cycles from a single command.

Reset
REQ-031 reset high at an edge SHALL force IDLE, enable_clk=0, cmd_ready=1, halted=1, bp_halted=0, done=0, step_remaining=0 and cycles_run=0, even mid-STEP or RUN.
REQ-032 A command presented in the same cycle as reset SHALL be discarded.

Verification
REQ-033 Bench SHALL drive: reset, then STEP N=3 -> enable_clk high exactly 3 cycles, step_remaining 3,2,1,0, done one cycle after, cycles_run=3.
REQ-034 Bench SHALL drive: RUN, wait 10 cycles, HALT -> enable_clk low next cycle, done pulse, cycles_run=11.
REQ-035 Bench SHALL drive: RUN, then bp_hit for 1 cycle -> IDLE, bp_halted=1, done=1; next RUN -> bp_halted=0.
REQ-036 Bench SHALL drive: STEP N=0 -> no enable pulse, done at k+1; STEP N=5 with cmd_valid held -> cmd_ready=0 for 5 cycles.
REQ-037 Bench SHALL drive: cycles_run preset near wrap with CYCLE_WIDTH=4, RUN 3 cycles from 14 -> reads 15,0,1; CLEAR_COUNT during RUN -> 0 next cycle.
REQ-038 Bench SHALL drive: reset asserted mid-STEP N=100 -> all outputs at reset values next cycle, no done pulse.
